// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: change codes, machine and dispenser state
// encodings, and small helpers for the change arithmetic.
package vm_pkg;

  // Change codes count Rs5 units
  localparam logic [2:0] RS_0  = 3'b000;
  localparam logic [2:0] RS_5  = 3'b001;
  localparam logic [2:0] RS_10 = 3'b010;
  localparam logic [2:0] RS_15 = 3'b011;
  localparam logic [2:0] RS_20 = 3'b100;
  localparam logic [2:0] RS_25 = 3'b101;

  localparam logic [2:0] CHANGE_MAX = RS_25;

  // Front-end vending machine states, owned by the coin-collection FSM
  typedef enum logic [2:0] {
    VM_IDLE     = 3'd0,
    VM_COIN5    = 3'd1,
    VM_COIN10   = 3'd2,
    VM_DISPENSE = 3'd3,
    VM_RETURN   = 3'd4
  } vm_state_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOTOR   = 2'd1,
    REQ     = 2'd2,
    ACK_LOW = 2'd3
  } disp_state_e;

  typedef enum logic [1:0] {
    HS_IDLE     = 2'd0,
    HS_REQ      = 2'd1,
    HS_WAIT_LOW = 2'd2
  } hs_state_e;

  function automatic logic change_legal(input logic [2:0] code);
    return code <= CHANGE_MAX;
  endfunction

  // Rs5 units consumed by one coin: Rs10 coin when sel=1, Rs5 otherwise
  function automatic logic [2:0] coin_units(input logic sel);
    return sel ? 3'd2 : 3'd1;
  endfunction

endpackage

// File: rtl/hopper_handshake.sv
// Four-phase request/acknowledge with the coin hopper for one coin at a time,
// with a per-phase timeout on each awaited acknowledge level.
module hopper_handshake
  import vm_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      start_i,
  input  logic      sel_i,
  input  logic      coin_ack_i,
  output logic      coin_req_o,
  output logic      coin_sel_o,
  output logic      taken_o,
  output logic      done_o,
  output logic      timeout_o,
  output hs_state_e state_o
);

  // Handshake: coin_req rises with a stable coin_sel; hopper raises coin_ack
  // once the coin is out; coin_req drops; hopper drops coin_ack; the coin is
  // complete and the next request may rise on that same edge.
  localparam logic [7:0] T_LAST = 8'(ACK_TIMEOUT - 1);

  hs_state_e  state_q, state_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       req_q, req_d;
  logic       sel_q, sel_d;
  logic       expired;

  assign expired = (tcnt_q == T_LAST);

  // Events depend only on current state and the hopper level, never on start_i
  always_comb begin
    taken_o   = 1'b0;
    done_o    = 1'b0;
    timeout_o = 1'b0;
    case (state_q)
      HS_REQ: begin
        if (coin_ack_i)   taken_o   = 1'b1;
        else if (expired) timeout_o = 1'b1;
      end
      HS_WAIT_LOW: begin
        if (!coin_ack_i)  done_o    = 1'b1;
        else if (expired) timeout_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    req_d   = 1'b0;
    sel_d   = 1'b0;
    case (state_q)
      HS_IDLE: begin
        if (start_i) begin
          state_d = HS_REQ;
          tcnt_d  = '0;
        end
      end
      HS_REQ: begin
        if (coin_ack_i) begin
          state_d = HS_WAIT_LOW;
          tcnt_d  = '0;
        end else if (expired) begin
          state_d = HS_IDLE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      HS_WAIT_LOW: begin
        if (!coin_ack_i) begin
          state_d = start_i ? HS_REQ : HS_IDLE;
          tcnt_d  = '0;
        end else if (expired) begin
          state_d = HS_IDLE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      default: state_d = HS_IDLE;
    endcase
    req_d = (state_d == HS_REQ);
    // Denomination is captured on entry and held for the whole request
    if (state_d == HS_REQ) begin
      sel_d = (state_q == HS_REQ) ? sel_q : sel_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HS_IDLE;
      tcnt_q  <= '0;
      req_q   <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      req_q   <= req_d;
      sel_q   <= sel_d;
    end
  end

  assign coin_req_o = req_q;
  assign coin_sel_o = sel_q;
  assign state_o    = state_q;

endmodule

// File: rtl/change_dispenser.sv
// Dispense back end: runs the product motor for a fixed time, then pays change
// greedily in Rs10/Rs5 coins through the hopper handshake. Tracks errors and vends.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int unsigned MOTOR_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vend,
  input  logic [2:0]  change,
  input  logic        coin_ack,
  output logic        motor_on,
  output logic        coin_req,
  output logic        coin_sel,
  output logic        busy,
  output logic        err,
  output logic [7:0]  vend_cnt,
  output disp_state_e dbg_state,
  output hs_state_e   dbg_hs_state,
  output logic [2:0]  dbg_remaining
);

  localparam logic [7:0] M_LAST = 8'(MOTOR_CYCLES - 1);

  disp_state_e state_q, state_d;
  logic [2:0]  rem_q, rem_d;
  logic [7:0]  mcnt_q, mcnt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        motor_q, motor_d;
  logic        busy_q, busy_d;

  logic        hs_start;
  logic        hs_taken;
  logic        hs_done;
  logic        hs_timeout;

  hopper_handshake #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_hopper (
    .clk_i     (clk),
    .rst_ni    (rst),
    .start_i   (hs_start),
    .sel_i     (rem_q >= 3'd2),
    .coin_ack_i(coin_ack),
    .coin_req_o(coin_req),
    .coin_sel_o(coin_sel),
    .taken_o   (hs_taken),
    .done_o    (hs_done),
    .timeout_o (hs_timeout),
    .state_o   (dbg_hs_state)
  );

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    mcnt_d   = mcnt_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    hs_start = 1'b0;

    // A strobe outside IDLE is dropped but remembered as an error
    if (vend && (state_q != IDLE)) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (vend) begin
          state_d = MOTOR;
          mcnt_d  = '0;
          cnt_d   = cnt_q + 8'd1;
          if (change_legal(change)) begin
            rem_d = change;
          end else begin
            rem_d = '0;
            err_d = 1'b1;
          end
        end
      end
      MOTOR: begin
        if (mcnt_q == M_LAST) begin
          if (rem_q != '0) begin
            state_d  = REQ;
            hs_start = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          mcnt_d = mcnt_q + 8'd1;
        end
      end
      REQ: begin
        if (hs_timeout) begin
          state_d = IDLE;
          rem_d   = '0;
          err_d   = 1'b1;
        end else if (hs_taken) begin
          rem_d   = rem_q - coin_units(coin_sel);
          state_d = ACK_LOW;
        end
      end
      ACK_LOW: begin
        if (hs_timeout) begin
          state_d = IDLE;
          rem_d   = '0;
          err_d   = 1'b1;
        end else if (hs_done) begin
          if (rem_q != '0) begin
            state_d  = REQ;
            hs_start = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    motor_d = (state_d == MOTOR);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      mcnt_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      motor_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      mcnt_q  <= mcnt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      motor_q <= motor_d;
      busy_q  <= busy_d;
    end
  end

  assign motor_on      = motor_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign vend_cnt      = cnt_q;
  assign dbg_state     = state_q;
  assign dbg_remaining = rem_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized vends, checked
// against a transaction-level model of payout, timing, error and count rules.
module tb_change_dispenser;
  import vm_pkg::*;

  localparam int unsigned MOTOR_CYCLES = 4;
  localparam int unsigned ACK_TIMEOUT  = 15;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vend = 1'b0;
  logic [2:0]  change = 3'd0;
  logic        coin_ack = 1'b0;
  logic        motor_on, coin_req, coin_sel, busy, err;
  logic [7:0]  vend_cnt;
  disp_state_e dbg_state;
  hs_state_e   dbg_hs_state;
  logic [2:0]  dbg_remaining;

  always #5 clk = ~clk;

  change_dispenser #(
    .MOTOR_CYCLES(MOTOR_CYCLES),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vend         (vend),
    .change       (change),
    .coin_ack     (coin_ack),
    .motor_on     (motor_on),
    .coin_req     (coin_req),
    .coin_sel     (coin_sel),
    .busy         (busy),
    .err          (err),
    .vend_cnt     (vend_cnt),
    .dbg_state    (dbg_state),
    .dbg_hs_state (dbg_hs_state),
    .dbg_remaining(dbg_remaining)
  );

  // ---------------- scoreboard ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_cnt  = 8'd0;
  logic       exp_err  = 1'b0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_motor"}, motor_on, 0);
    check({tag, "_req"}, coin_req, 0);
    check({tag, "_sel"}, coin_sel, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_cnt"}, vend_cnt, 0);
    check({tag, "_rem"}, dbg_remaining, 0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; vend = 1'b0; coin_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 8'd0;
    exp_err = 1'b0;
    @(negedge clk);
  endtask

  // One full vend: strobe, motor phase, payout. ack_dly<0 means random hopper delay;
  // dead means the hopper never acknowledges; rev repeats the strobe during the motor phase.
  task automatic run_vend(input logic [2:0] ch, input int ack_dly, input bit dead, input bit rev);
    int  rupees;
    int  n;
    int  d;
    int  d2;
    logic sel;
    rupees = (ch <= 3'd5) ? int'(ch) * 5 : 0;
    exp_q.delete();
    for (int i = 0; i < rupees / 10; i++) exp_q.push_back(1'b1);
    if ((rupees % 10) != 0) exp_q.push_back(1'b0);
    if (ch > 3'd5) exp_err = 1'b1;
    exp_cnt = exp_cnt + 8'd1;

    vend = 1'b1; change = ch;
    @(negedge clk);
    vend = 1'b0; change = 3'($urandom);
    check("vend_busy", busy, 1);
    check("vend_cnt", vend_cnt, exp_cnt);

    n = 0;
    while (motor_on === 1'b1 && n < 300) begin
      n++;
      if (rev && n == 2) begin
        vend = 1'b1; change = 3'($urandom);
        exp_err = 1'b1;
      end else begin
        vend = 1'b0;
      end
      @(negedge clk);
    end
    vend = 1'b0;
    check("motor_cycles", n, MOTOR_CYCLES);
    check("cnt_after_motor", vend_cnt, exp_cnt);

    if (exp_q.size() == 0) begin
      check("no_coin_req", coin_req, 0);
      check("idle_after_motor", busy, 0);
    end else if (dead) begin
      check("first_sel", coin_sel, exp_q[0]);
      n = 0;
      while (coin_req === 1'b1 && n < 100) begin
        n++;
        @(negedge clk);
      end
      exp_err = 1'b1;
      exp_q.delete();
      check("timeout_req_cycles", n, ACK_TIMEOUT);
      check("timeout_busy", busy, 0);
      check("timeout_rem", dbg_remaining, 0);
    end else begin
      while (exp_q.size() > 0) begin
        sel = exp_q.pop_front();
        check("coin_req_rise", coin_req, 1);
        check("coin_sel", coin_sel, sel);
        d  = (ack_dly < 0) ? int'($urandom_range(0, 5)) : ack_dly;
        d2 = (ack_dly < 0) ? int'($urandom_range(0, 5)) : ack_dly;
        repeat (d) begin
          @(negedge clk);
          check("coin_sel_stable", {coin_req, coin_sel}, {1'b1, sel});
        end
        coin_ack = 1'b1;
        @(negedge clk);
        check("coin_req_drop", coin_req, 0);
        repeat (d2) begin
          @(negedge clk);
          check("gap_no_req", coin_req, 0);
        end
        coin_ack = 1'b0;
        @(negedge clk);
      end
      check("busy_fall", busy, 0);
      check("rem_zero", dbg_remaining, 0);
    end
    check("err_flag", err, exp_err);
    check("state_idle", 32'(dbg_state), 32'(IDLE));
    check("hs_idle", 32'(dbg_hs_state), 32'(HS_IDLE));
    check("cnt_end", vend_cnt, exp_cnt);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [2:0] ch;
    repeat (3) @(negedge clk);
    check_cleared("in_reset");
    rst = 1'b1;
    @(negedge clk);
    check_cleared("after_reset");

    run_vend(3'd0, -1, 1'b0, 1'b0);
    run_vend(3'd5, 2, 1'b0, 1'b0);
    run_vend(3'd4, -1, 1'b0, 1'b1);

    apply_reset();
    run_vend(3'd2, -1, 1'b1, 1'b0);

    apply_reset();
    run_vend(3'd7, -1, 1'b0, 1'b0);

    apply_reset();
    for (int c = 1; c <= 5; c++) run_vend(3'(c), -1, 1'b0, 1'b0);
    check("legal_codes_no_err", err, 0);

    for (int i = 0; i < 30; i++) begin
      ch = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      run_vend(ch, -1, ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
    end

    // Asynchronous reset in the middle of a payout
    apply_reset();
    vend = 1'b1; change = 3'd5;
    @(negedge clk);
    vend = 1'b0; change = 3'd0;
    n = 0;
    while (coin_req !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("midpay_req_seen", coin_req, 1);
    #2 rst = 1'b0;
    #1 check_cleared("async_reset");
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 8'd0;
    exp_err = 1'b0;
    @(negedge clk);

    // Count wrap: 256 accepted vends
    for (int i = 0; i < 256; i++) begin
      vend = 1'b1; change = 3'd0;
      @(negedge clk);
      vend = 1'b0;
      exp_cnt = exp_cnt + 8'd1;
      n = 0;
      while (busy === 1'b1 && n < 50) begin
        n++;
        @(negedge clk);
      end
      if (n >= 50) check("wrap_idle_timeout", busy, 0);
      if (i == 254) check("cnt_255", vend_cnt, exp_cnt);
    end
    check("cnt_wrap", vend_cnt, exp_cnt);
    check("wrap_err", err, exp_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
